alu_8bit: RTL and testbench
===========================

ALU_8BIT -- requirements
Module: alu_8bit

Interface
Parameters: none; datapath fixed at 8 bits.
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk edge only.
REQ-003 sel  input  3  operation select.
REQ-004 A  input  8  operand A.
REQ-005 B  input  8  operand B.
REQ-006 C  output  8  combinational result of current sel/A/B.
REQ-007 C_q  output  8  registered copy of C.
REQ-008 zero_q  output  1  registered flag: C == 0.
REQ-009 neg_q  output  1  registered flag: C[7].
REQ-010 carry_q  output  1  registered carry/borrow from ADD/SUB; 0 for all other ops.

Function
REQ-011 C SHALL be purely combinational from sel, A, B: settles within the same cycle, no dependence on clk or rst_n.
REQ-012 sel 000 -> C = B (pass B).
REQ-013 sel 001 -> C = ~B (bitwise NOT of B; A ignored).
REQ-014 sel 010 -> C = A & B.
REQ-015 sel 011 -> C = A | B.
REQ-016 sel 100 -> C = A ^ B.
REQ-017 sel 101 -> C = A + B mod 256; carry = bit 8 of 9-bit sum.
REQ-018 sel 110 -> C = A - B mod 256; carry = 1 when A < B unsigned (borrow).
REQ-019 sel 111 -> C = A (pass A).
REQ-020 Each rising clk edge with rst_n=1: C_q <= C, zero_q <= (C==0), neg_q <= C[7], carry_q <= carry of current op.
REQ-021 Registered outputs lag C by exactly one cycle; no enable, updated every cycle.
REQ-022 Unsigned arithmetic only; no overflow flag; no X propagation beyond inputs.

Reset
REQ-023 On rising clk with rst_n=0: C_q=8'h00, zero_q=1, neg_q=0, carry_q=0.
REQ-024 Reset has priority over normal update; C (combinational) is unaffected by reset.
REQ-025 Deassertion: first rising edge with rst_n=1 captures current C normally.

Structure
REQ-026 Opcode constants (OP_PASS_B=000, OP_NOT_B=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_ADD=101, OP_SUB=110, OP_PASS_A=111) SHALL live in a shared package alu_pkg.
REQ-027 Combinational datapath SHALL be one sub-module alu_8bit_core (sel, A, B -> C, carry); top adds flag logic and output registers.

Verification
REQ-028 sel=000, A=3, B=12 -> C=12 within 1 time unit; next edge C_q=12, zero_q=0.
REQ-029 sel=001, A=3, B=12 -> C=8'hF3; next edge neg_q=1.
REQ-030 sel=010 A=F3 B=25 -> C=21; sel=011 A=73 B=8B -> C=FB; sel=100 A=A3 B=45 -> C=E6.
REQ-031 sel=101 A=FF B=01 -> C=00; next edge C_q=00, zero_q=1, carry_q=1.
REQ-032 sel=110 A=05 B=07 -> C=FE; next edge carry_q=1, neg_q=1.
REQ-033 rst_n=0 held one edge during sel=101 A=FF B=01 -> C_q=00, zero_q=1, carry_q=0, neg_q=0 while C=00 still combinational.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and widths shared by the 8-bit ALU
package alu_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        OP_PASS_B = 3'b000,
        OP_NOT_B  = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_XOR    = 3'b100,
        OP_ADD    = 3'b101,
        OP_SUB    = 3'b110,
        OP_PASS_A = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_8bit_if.sv
// rtl/alu_8bit_if.sv - operand/result bundle between the ALU and its user
interface alu_8bit_if;
    import alu_pkg::*;

    logic [2:0]        sel;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] C;
    logic [DATA_W-1:0] C_q;
    logic              zero_q;
    logic              neg_q;
    logic              carry_q;

    modport master (
        output sel, A, B,
        input  C, C_q, zero_q, neg_q, carry_q
    );

    modport slave (
        input  sel, A, B,
        output C, C_q, zero_q, neg_q, carry_q
    );

endinterface

// File: rtl/alu_8bit_core.sv
// rtl/alu_8bit_core.sv - purely combinational ALU datapath with carry/borrow
module alu_8bit_core
    import alu_pkg::*;
(
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] C,
    output logic              carry
);

    // Both arithmetic ops use a 9-bit result; bit 8 is carry for ADD and
    // the borrow (A < B unsigned) for SUB, since the extended difference wraps.
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    // Result mux; carry stays 0 for every non-arithmetic op
    always_comb begin
        C     = '0;
        carry = 1'b0;
        case (alu_op_e'(sel))
            OP_PASS_B: C = B;
            OP_NOT_B:  C = ~B;
            OP_AND:    C = A & B;
            OP_OR:     C = A | B;
            OP_XOR:    C = A ^ B;
            OP_ADD: begin
                C     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                C     = diff[DATA_W-1:0];
                carry = diff[DATA_W];
            end
            OP_PASS_A: C = A;
            default:   C = '0;
        endcase
    end

endmodule

// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - 8-bit ALU top: combinational result plus registered copy and flags
module alu_8bit
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    alu_8bit_if.slave   bus
);

    logic [DATA_W-1:0] c;
    logic              carry;

    alu_8bit_core u_core (
        .sel   (bus.sel),
        .A     (bus.A),
        .B     (bus.B),
        .C     (c),
        .carry (carry)
    );

    // The combinational result goes straight out, untouched by reset
    assign bus.C = c;

    // Capture result and flags every cycle; reset forces the all-zero result state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.C_q     <= '0;
            bus.zero_q  <= 1'b1;
            bus.neg_q   <= 1'b0;
            bus.carry_q <= 1'b0;
        end else begin
            bus.C_q     <= c;
            bus.zero_q  <= (c == '0);
            bus.neg_q   <= c[DATA_W-1];
            bus.carry_q <= carry;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// tb/tb_alu_8bit.sv - directed and random scoreboard bench for alu_8bit
module tb_alu_8bit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_8bit_if bus ();

    alu_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] c_q;
        logic       zero_q;
        logic       neg_q;
        logic       carry_q;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] c, output logic cy);
        int unsigned wide;
        cy = 1'b0;
        case (s)
            3'd0: c = b;
            3'd1: c = 8'hFF - b;
            3'd2: c = a & b;
            3'd3: c = a | b;
            3'd4: c = (a | b) & ~(a & b);
            3'd5: begin
                wide = int'(a) + int'(b);
                c    = wide[7:0];
                cy   = (wide > 255);
            end
            3'd6: begin
                wide = (int'(a) + 256 - int'(b)) % 256;
                c    = wide[7:0];
                cy   = (a < b);
            end
            default: c = a;
        endcase
    endfunction

    task automatic step(input string tag, input logic r, input logic [2:0] s,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_c, input logic exp_cy);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n   = r;
        bus.sel = s;
        bus.A   = a;
        bus.B   = b;
        #1;
        check({tag, ".C"}, bus.C, exp_c);
        if (r) begin
            e.c_q = exp_c; e.zero_q = (exp_c == 8'h00); e.neg_q = exp_c[7]; e.carry_q = exp_cy;
        end else begin
            e.c_q = 8'h00; e.zero_q = 1'b1; e.neg_q = 1'b0; e.carry_q = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 8'h01, 8'h00);
        end else begin
            got = sb.pop_front();
            check({tag, ".C_q"},     bus.C_q,     got.c_q);
            check({tag, ".zero_q"},  bus.zero_q,  got.zero_q);
            check({tag, ".neg_q"},   bus.neg_q,   got.neg_q);
            check({tag, ".carry_q"}, bus.carry_q, got.carry_q);
        end
    endtask

    task automatic rstep(input string tag, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] c;
        logic       cy;
        model(s, a, b, c, cy);
        step(tag, 1'b1, s, a, b, c, cy);
    endtask

    initial begin
        bus.sel = OP_PASS_B;
        bus.A   = 8'h00;
        bus.B   = 8'h00;

        step("reset",   1'b0, OP_PASS_A, 8'h5A, 8'h00, 8'h5A, 1'b0);
        step("pass_b",  1'b1, OP_PASS_B, 8'h03, 8'h0C, 8'h0C, 1'b0);
        step("not_b",   1'b1, OP_NOT_B,  8'h03, 8'h0C, 8'hF3, 1'b0);
        step("and",     1'b1, OP_AND,    8'hF3, 8'h25, 8'h21, 1'b0);
        step("or",      1'b1, OP_OR,     8'h73, 8'h8B, 8'hFB, 1'b0);
        step("xor",     1'b1, OP_XOR,    8'hA3, 8'h45, 8'hE6, 1'b0);
        step("add_wrap",1'b1, OP_ADD,    8'hFF, 8'h01, 8'h00, 1'b1);
        step("sub_brw", 1'b1, OP_SUB,    8'h05, 8'h07, 8'hFE, 1'b1);
        step("add_80",  1'b1, OP_ADD,    8'h80, 8'h80, 8'h00, 1'b1);
        step("add_nc",  1'b1, OP_ADD,    8'h7F, 8'h01, 8'h80, 1'b0);
        step("sub_eq",  1'b1, OP_SUB,    8'h42, 8'h42, 8'h00, 1'b0);
        step("sub_nb",  1'b1, OP_SUB,    8'h07, 8'h05, 8'h02, 1'b0);
        step("pass_a",  1'b1, OP_PASS_A, 8'h9C, 8'h11, 8'h9C, 1'b0);
        step("rst_add", 1'b0, OP_ADD,    8'hFF, 8'h01, 8'h00, 1'b1);
        step("deassert",1'b1, OP_ADD,    8'hFF, 8'h01, 8'h00, 1'b1);
        step("sub_zero",1'b1, OP_SUB,    8'h00, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 32; i++) begin
            rstep("rand", 3'(i % 8), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        check("sb_drained", 8'(sb.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
